// File: rtl/fp_addsub_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency complex add/sub unit.
// Define FPARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise requester 0 has priority.
module fp_addsub_arbiter #(
    parameter int LAT = 1,
    parameter int W   = 48
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         lock0,
    input  logic         lock1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         mode0,
    input  logic         mode1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W-1:0] fp_in1,
    output logic [W-1:0] fp_in2,
    output logic         fp_mode,
    input  logic [W-1:0] fp_out,
    output logic [W-1:0] res0,
    output logic [W-1:0] res1,
    output logic         vld0,
    output logic         vld1,
    output logic [15:0]  conflict_cnt
);

    typedef enum logic [1:0] {FREE, OWN0, OWN1} lockState_t;

    lockState_t     lockState, lockStateNext;
    logic           grant0, grant1;
    logic [LAT-1:0] tagVld_p;
    logic [LAT-1:0] tagId_p;
    logic [15:0]    conflictCnt;
`ifdef FPARB_ROUND_ROBIN_EN
    logic           lastGnt;
`endif

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        lockStateNext = FREE;
        grant0        = 1'b0;
        grant1        = 1'b0;
        if (lockState == OWN0 && req0 && lock0) begin
            grant0 = 1'b1;
        end else if (lockState == OWN1 && req1 && lock1) begin
            grant1 = 1'b1;
        end else if (req0 && req1) begin
`ifdef FPARB_ROUND_ROBIN_EN
            if (lastGnt) grant0 = 1'b1;
            else         grant1 = 1'b1;
`else
            grant0 = 1'b1;
`endif
        end else begin
            grant0 = req0;
            grant1 = req1;
        end
        // Reset is synchronous, but grants must already be suppressed in the reset cycle.
        if (!reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
        if (grant0 && lock0)      lockStateNext = OWN0;
        else if (grant1 && lock1) lockStateNext = OWN1;
    end

    always_ff @(posedge clock) begin
        if (!reset) lockState <= FREE;
        else        lockState <= lockStateNext;
    end

`ifdef FPARB_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        if (!reset)                lastGnt <= 1'b1;
        else if (grant0 || grant1) lastGnt <= grant1;
    end
`endif

    // Stage p0..p(LAT-1): tag pipeline tracking the add/sub unit latency
    always_ff @(posedge clock) begin
        if (!reset) begin
            tagVld_p <= '0;
        end else begin
            tagVld_p[0] <= grant0 | grant1;
            for (int i = 1; i < LAT; i++) tagVld_p[i] <= tagVld_p[i-1];
        end
    end

    always_ff @(posedge clock) begin
        tagId_p[0] <= grant1;
        for (int i = 1; i < LAT; i++) tagId_p[i] <= tagId_p[i-1];
    end

    always_ff @(posedge clock) begin
        if (!reset)            conflictCnt <= '0;
        else if (req0 && req1) conflictCnt <= satInc(conflictCnt);
    end

    assign gnt0         = grant0;
    assign gnt1         = grant1;
    assign fp_in1       = grant0 ? a0 : (grant1 ? a1 : '0);
    assign fp_in2       = grant0 ? b0 : (grant1 ? b1 : '0);
    assign fp_mode      = grant0 ? mode0 : (grant1 ? mode1 : 1'b1);
    assign vld0         = reset & tagVld_p[LAT-1] & ~tagId_p[LAT-1];
    assign vld1         = reset & tagVld_p[LAT-1] &  tagId_p[LAT-1];
    assign res0         = vld0 ? fp_out : '0;
    assign res1         = vld1 ? fp_out : '0;
    assign conflict_cnt = reset ? conflictCnt : 16'd0;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: LAT=1 and LAT=3 instances against a queue-based model,
// plus directed scenarios with literal expectations.
module tb_fp_addsub_arbiter;

    localparam int W    = 48;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
`ifdef FPARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, req0, req1, lock0, lock1, mode0, mode1;
    logic [W-1:0] a0, b0, a1, b1;

    logic gnt0A, gnt1A, fpModeA, vld0A, vld1A;
    logic [W-1:0] fpIn1A, fpIn2A, fpOutA, res0A, res1A;
    logic [15:0] cntA;
    logic gnt0B, gnt1B, fpModeB, vld0B, vld1B;
    logic [W-1:0] fpIn1B, fpIn2B, fpOutB, res0B, res1B;
    logic [15:0] cntB;

    always #5 clock = ~clock;

    fp_addsub_arbiter #(.LAT(LAT1), .W(W)) dutA (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .mode0(mode0), .mode1(mode1),
        .gnt0(gnt0A), .gnt1(gnt1A), .fp_in1(fpIn1A), .fp_in2(fpIn2A), .fp_mode(fpModeA),
        .fp_out(fpOutA), .res0(res0A), .res1(res1A), .vld0(vld0A), .vld1(vld1A),
        .conflict_cnt(cntA));

    fp_addsub_arbiter #(.LAT(LAT3), .W(W)) dutB (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .mode0(mode0), .mode1(mode1),
        .gnt0(gnt0B), .gnt1(gnt1B), .fp_in1(fpIn1B), .fp_in2(fpIn2B), .fp_mode(fpModeB),
        .fp_out(fpOutB), .res0(res0B), .res1(res1B), .vld0(vld0B), .vld1(vld1B),
        .conflict_cnt(cntB));

    // Shared add/sub unit emulation, one per instance latency
    logic [W-1:0] fpQA;
    logic [W-1:0] fpQB [LAT3];
    always @(posedge clock) begin
        fpQA <= fpModeA ? fpIn1A - fpIn2A : fpIn1A + fpIn2A;
        fpQB[0] <= fpModeB ? fpIn1B - fpIn2B : fpIn1B + fpIn2B;
        for (int i = 1; i < LAT3; i++) fpQB[i] <= fpQB[i-1];
    end
    assign fpOutA = fpQA;
    assign fpOutB = fpQB[LAT3-1];

    typedef struct { int due; bit id; logic [W-1:0] val; } op_t;
    op_t qA[$];
    op_t qB[$];
    int  mOwner = -1;
    bit  mLast  = 1'b1;
    logic [15:0] mCnt = 16'd0;
    int  cyc = 0;
    int  nTests = 0;
    int  nFail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkModel();
        int eg;
        logic [W-1:0] ea, eb, val, eValA, eValB;
        logic em;
        bit eV0A, eV1A, eV0B, eV1B;
        eg = -1;
        if (reset) begin
            if (mOwner == 0 && req0 && lock0)      eg = 0;
            else if (mOwner == 1 && req1 && lock1) eg = 1;
            else if (req0 && req1)                 eg = RR ? (mLast ? 0 : 1) : 0;
            else if (req0)                         eg = 0;
            else if (req1)                         eg = 1;
        end
        ea = (eg == 0) ? a0 : ((eg == 1) ? a1 : '0);
        eb = (eg == 0) ? b0 : ((eg == 1) ? b1 : '0);
        em = (eg == 0) ? mode0 : ((eg == 1) ? mode1 : 1'b1);
        eV0A = 0; eV1A = 0; eV0B = 0; eV1B = 0; eValA = '0; eValB = '0;
        if (reset && qA.size() > 0 && qA[0].due == cyc) begin
            if (qA[0].id) eV1A = 1; else eV0A = 1;
            eValA = qA[0].val;
        end
        if (reset && qB.size() > 0 && qB[0].due == cyc) begin
            if (qB[0].id) eV1B = 1; else eV0B = 1;
            eValB = qB[0].val;
        end
        chk("gnt0A", 64'(gnt0A), 64'(eg == 0));
        chk("gnt1A", 64'(gnt1A), 64'(eg == 1));
        chk("gnt0B", 64'(gnt0B), 64'(eg == 0));
        chk("gnt1B", 64'(gnt1B), 64'(eg == 1));
        chk("fp_in1A", 64'(fpIn1A), 64'(ea));
        chk("fp_in2A", 64'(fpIn2A), 64'(eb));
        chk("fp_modeA", 64'(fpModeA), 64'(em));
        chk("fp_in1B", 64'(fpIn1B), 64'(ea));
        chk("fp_modeB", 64'(fpModeB), 64'(em));
        chk("vld0A", 64'(vld0A), 64'(eV0A));
        chk("vld1A", 64'(vld1A), 64'(eV1A));
        chk("res0A", 64'(res0A), 64'(eV0A ? eValA : '0));
        chk("res1A", 64'(res1A), 64'(eV1A ? eValA : '0));
        chk("vld0B", 64'(vld0B), 64'(eV0B));
        chk("vld1B", 64'(vld1B), 64'(eV1B));
        chk("res0B", 64'(res0B), 64'(eV0B ? eValB : '0));
        chk("res1B", 64'(res1B), 64'(eV1B ? eValB : '0));
        chk("cntA", 64'(cntA), 64'(reset ? mCnt : 16'd0));
        chk("cntB", 64'(cntB), 64'(reset ? mCnt : 16'd0));
        if (!reset) begin
            qA.delete(); qB.delete();
            mOwner = -1; mLast = 1'b1; mCnt = 16'd0;
        end else begin
            if (qA.size() > 0 && qA[0].due == cyc) void'(qA.pop_front());
            if (qB.size() > 0 && qB[0].due == cyc) void'(qB.pop_front());
            if (eg >= 0) begin
                val = em ? ea - eb : ea + eb;
                qA.push_back('{cyc + LAT1, eg == 1, val});
                qB.push_back('{cyc + LAT3, eg == 1, val});
                mLast  = (eg == 1);
                mOwner = ((eg == 0) ? lock0 : lock1) ? eg : -1;
            end else begin
                mOwner = -1;
            end
            if (req0 && req1 && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        end
        cyc++;
    endtask

    task automatic doCycle(input bit rst, input bit r0, input bit l0, input bit m0,
                           input logic [W-1:0] x0, input logic [W-1:0] y0,
                           input bit r1, input bit l1, input bit m1,
                           input logic [W-1:0] x1, input logic [W-1:0] y1);
        @(posedge clock);
        #1;
        reset = rst; req0 = r0; lock0 = l0; mode0 = m0; a0 = x0; b0 = y0;
        req1 = r1; lock1 = l1; mode1 = m1; a1 = x1; b1 = y1;
        @(negedge clock);
        checkModel();
    endtask

    task automatic idle(input bit rst);
        doCycle(rst, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic both(input bit l0, input bit l1);
        doCycle(1, 1, l0, 0, 48'h100, 48'h1, 1, l1, 1, 48'h200, 48'h2);
    endtask

    initial begin
        reset = 0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; mode0 = 0; mode1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset state with requests pending
        doCycle(0, 1, 0, 0, 48'h5, 48'h6, 1, 0, 0, 48'h7, 48'h8);
        chk("rst_gnt0", 64'(gnt0A), 64'd0);
        chk("rst_fp_mode", 64'(fpModeA), 64'd1);
        chk("rst_cnt", 64'(cntA), 64'd0);
        idle(0);

        // Single request, subtract, first cycle out of reset
        doCycle(1, 1, 0, 1, 48'h10, 48'h4, 0, 0, 0, '0, '0);
        chk("single_gnt0", 64'(gnt0A), 64'd1);
        chk("single_fp_in1", 64'(fpIn1A), 64'h10);
        idle(1);
        chk("single_vld0A", 64'(vld0A), 64'd1);
        chk("single_res0A", 64'(res0A), 64'hC);
        chk("single_vld1A", 64'(vld1A), 64'd0);
        idle(1);
        idle(1);
        chk("single_res0B", 64'(res0B), 64'hC);

        // Four unlocked conflicts straight after reset
        idle(0);
        for (int i = 0; i < 4; i++) begin
            both(0, 0);
            chk("conflict_gnt1", 64'(gnt1A), 64'(RR ? (i % 2 == 1) : 1'b0));
            chk("conflict_gnt0", 64'(gnt0A), 64'(RR ? (i % 2 == 0) : 1'b1));
        end
        idle(1);
        chk("conflict_cnt4", 64'(cntA), 64'd4);

        // Requester 0 holds a lock for three cycles against a competing request
        idle(0);
        for (int i = 0; i < 3; i++) begin
            both(1, 0);
            chk("lock_gnt0", 64'(gnt0A), 64'd1);
        end
        doCycle(1, 0, 0, 0, '0, '0, 1, 0, 1, 48'h200, 48'h2);
        chk("lock_release_gnt1", 64'(gnt1A), 64'd1);
        idle(1);
        chk("lock_cnt3", 64'(cntA), 64'd3);

        // Reset pulse discards in-flight LAT=3 operations
        idle(0);
        for (int i = 0; i < 3; i++) doCycle(1, 1, 0, 0, 48'h30, 48'h3, 0, 0, 0, '0, '0);
        doCycle(0, 1, 0, 0, 48'h30, 48'h3, 0, 0, 0, '0, '0);
        chk("midrst_vld0B", 64'(vld0B), 64'd0);
        chk("midrst_gnt0", 64'(gnt0B), 64'd0);
        chk("midrst_fp_in1", 64'(fpIn1B), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("postrst_vld0B", 64'(vld0B), 64'd0);
        end

        // Counter saturation
        @(posedge clock);
        #1;
        reset = 1; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        force dutA.conflictCnt = 16'hFFFE;
        force dutB.conflictCnt = 16'hFFFE;
        @(negedge clock);
        mCnt = 16'hFFFE;
        checkModel();
        #1;
        release dutA.conflictCnt;
        release dutB.conflictCnt;
        for (int i = 0; i < 3; i++) both(0, 0);
        idle(1);
        chk("sat_cntA", 64'(cntA), 64'hFFFF);
        chk("sat_cntB", 64'(cntB), 64'hFFFF);

        // Randomized traffic with sticky locks and occasional reset
        for (int i = 0; i < 1500; i++) begin
            doCycle($urandom_range(0, 39) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom()),
                    W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom()),
                    W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
